// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches one word per request/grant/response
// handshake, holds it for decode and handles execute-side redirects.
module instruction_fetch #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter int                        BUS_INST_WIDTH = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [BUS_DATA_WIDTH-1:0] imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [BUS_INST_WIDTH-1:0] imem_rdata,
  input  logic                      id_ready,
  input  logic                      redirect_en,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic [BUS_INST_WIDTH-1:0] inst,
  output logic [BUS_DATA_WIDTH-1:0] IF_PCplus4_out,
  output logic                      if_valid
);

  localparam logic [BUS_INST_WIDTH-1:0] NOP = BUS_INST_WIDTH'(32'h0100_0000);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  state_e                    state_q;
  logic [BUS_DATA_WIDTH-1:0] pc_q;
  logic [BUS_INST_WIDTH-1:0] inst_q;
  logic [BUS_DATA_WIDTH-1:0] pcp4_q;
  logic [BUS_DATA_WIDTH-1:0] pc_plus4;
  logic [BUS_DATA_WIDTH-1:0] redir_aligned;
  logic                      hold_vld;

  assign pc_plus4      = pc_q + BUS_DATA_WIDTH'(4);
  assign redir_aligned = {redirect_pc[BUS_DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      pcp4_q  <= '0;
    end else if (redirect_en) begin
      // A granted-but-unanswered request must have its response swallowed.
      pc_q   <= redir_aligned;
      inst_q <= NOP;
      pcp4_q <= '0;
      case (state_q)
        S_REQ:   state_q <= imem_gnt    ? S_DRAIN : S_REQ;
        S_WAIT:  state_q <= imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: state_q <= imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: if (imem_gnt) state_q <= S_WAIT;
        S_WAIT: if (imem_rvalid) begin
          inst_q  <= imem_rdata;
          pcp4_q  <= pc_plus4;
          state_q <= S_HOLD;
        end
        S_HOLD: if (id_ready) begin
          pc_q    <= pc_plus4;
          state_q <= S_REQ;
        end
        S_DRAIN: if (imem_rvalid) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;

  // Redirect masks the presented instruction so decode samples a NOP.
  assign hold_vld       = (state_q == S_HOLD);
  assign if_valid       = hold_vld & ~redirect_en;
  assign inst           = if_valid ? inst_q : NOP;
  assign IF_PCplus4_out = if_valid ? pcp4_q : '0;

endmodule
